// File: rtl/sample_match_filter.sv
// Key-set sample screen: matching samples go to a 16-entry FWFT FIFO.
// Saturating match/miss statistics track every accepted sample.
module sample_match_filter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] key0,
  input  logic [DATA_W-1:0] key1,
  input  logic [DATA_W-1:0] key2,
  input  logic [2:0]        key_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              hit;
  logic              accept;
  logic              push;
  logic              pop;

  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  assign hit = (key_en[0] && in_data == key0)
            || (key_en[1] && in_data == key1)
            || (key_en[2] && in_data == key2);

  assign accept = in_valid && in_ready;
  assign push   = accept && hit;
  assign pop    = out_valid && out_ready;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (push && !pop): level <= level + 1'b1;
        (pop && !push): level <= level - 1'b1;
        default:        level <= level;
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (accept) begin
      if (hit && match_cnt != CMAX)
        match_cnt <= match_cnt + 1'b1;
      if (!hit && miss_cnt != CMAX)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_match_filter.sv
// Directed bench for sample_match_filter with a queue-based
// reference model compared on every falling clock edge.
module tb_sample_match_filter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  key0, key1, key2;
  logic [2:0]  key_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] match_cnt;
  logic [15:0] miss_cnt;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];
  int mmatch = 0;
  int mmiss  = 0;
  logic [7:0] pat [3] = '{8'h05, 8'h0A, 8'h11};

  sample_match_filter dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .key0(key0), .key1(key1), .key2(key2),
    .key_en(key_en),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr),
    .match_cnt(match_cnt), .miss_cnt(miss_cnt),
    .level(level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, counters as plain ints.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mmatch = 0;
      mmiss  = 0;
    end else begin : mdl
      bit acc, h, pp;
      acc = in_valid && (q.size() != 16);
      h = (key_en[0] && in_data == key0)
       || (key_en[1] && in_data == key1)
       || (key_en[2] && in_data == key2);
      pp = (q.size() != 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc && h) q.push_back(in_data);
      if (cnt_clr) begin
        mmatch = 0;
        mmiss  = 0;
      end else if (acc) begin
        if (h && mmatch < 65535) mmatch++;
        if (!h && mmiss < 65535) mmiss++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_in_ready", in_ready, q.size() != 16);
      check("m_out_valid", out_valid, q.size() != 0);
      check("m_level", level, q.size());
      check("m_match", match_cnt, mmatch);
      check("m_miss", miss_cnt, mmiss);
      if (q.size() != 0)
        check("m_out_data", out_data, q[0]);
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1;
    step();
  endtask

  task automatic clr();
    in_valid = 0;
    cnt_clr  = 1;
    step();
    cnt_clr  = 0;
  endtask

  task automatic cmp_got(input string name);
    check({name, "_n"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check(name, got[i], expq[i]);
  endtask

  task automatic full_round();
    clr();
    out_ready = 0;
    key0 = 8'h05; key1 = 8'h0A; key2 = 8'h11;
    key_en = 3'b111;
    got.delete();
    expq.delete();
    for (int i = 0; i < 16; i++) begin
      send(pat[i % 3]);
      expq.push_back(pat[i % 3]);
    end
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    in_data  = 8'h11;
    in_valid = 1;
    repeat (3) step();
    check("held_not_counted", match_cnt, 16);
    out_ready = 1;
    step();
    check("slot_freed", in_ready, 1);
    check("after_pop_level", level, 15);
    step();
    in_valid = 0;
    expq.push_back(8'h11);
    check("held_accepted", match_cnt, 17);
    check("held_level", level, 15);
    repeat (20) step();
    check("drain_level", level, 0);
    cmp_got("full_order");
  endtask

  initial begin
    rst_n = 0; in_data = 0; in_valid = 0;
    key0 = 0; key1 = 0; key2 = 0; key_en = 0;
    out_ready = 0; cnt_clr = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_match", match_cnt, 0);
    check("rst_miss", miss_cnt, 0);

    // Filtering with all three keys.
    key0 = 8'h00; key1 = 8'h05; key2 = 8'h0A;
    key_en = 3'b111;
    out_ready = 1;
    got.delete();
    send(8'h00); send(8'h03); send(8'h05);
    send(8'h0A); send(8'hFF);
    in_valid = 0;
    repeat (3) step();
    expq = '{8'h00, 8'h05, 8'h0A};
    cmp_got("filter_order");
    check("filter_match", match_cnt, 3);
    check("filter_miss", miss_cnt, 2);

    // Only key1 enabled.
    clr();
    key_en = 3'b010;
    got.delete();
    send(8'h00); send(8'h05);
    in_valid = 0;
    repeat (3) step();
    expq = '{8'h05};
    cmp_got("keyen_order");
    check("keyen_match", match_cnt, 1);
    check("keyen_miss", miss_cnt, 1);

    full_round();
    full_round();

    // Concurrent push/pop at level 8.
    clr();
    out_ready = 0;
    key_en = 3'b111;
    got.delete();
    expq.delete();
    for (int i = 0; i < 8; i++) begin
      send(pat[i % 3]);
      expq.push_back(pat[i % 3]);
    end
    check("conc_level0", level, 8);
    out_ready = 1;
    for (int i = 8; i < 18; i++) begin
      send(pat[i % 3]);
      expq.push_back(pat[i % 3]);
      check("conc_level", level, 8);
    end
    in_valid = 0;
    repeat (12) step();
    cmp_got("conc_order");

    // Miss counter saturation and clear priority.
    clr();
    key_en = 3'b000;
    out_ready = 1;
    in_data = 8'h33;
    in_valid = 1;
    repeat (70000) step();
    check("sat_miss", miss_cnt, 16'hFFFF);
    repeat (3) step();
    check("sat_hold", miss_cnt, 16'hFFFF);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    in_valid = 0;
    check("clr_wins", miss_cnt, 0);
    check("clr_match", match_cnt, 0);

    // Asynchronous reset in mid-stream.
    out_ready = 0;
    key_en = 3'b111;
    key0 = 8'h05;
    repeat (5) send(8'h05);
    in_valid = 0;
    check("pre_rst_level", level, 5);
    rst_n = 0;
    #1;
    check("arst_level", level, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_match", match_cnt, 0);
    check("arst_miss", miss_cnt, 0);
    step();
    rst_n = 1;
    step();
    check("post_rst_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
